// File: rtl/pos_cell_reader_pkg.sv
// Shared types and constants for the cell position reader.
// Holds the reader FSM state enum, the output FIFO depth and the default
// widths used by pos_cell_reader and pos_cell_reader_fifo.
package md_pos_pkg;

  localparam int DEF_DATA_WIDTH   = 96;   // {posz, posy, posx}, 32 bits each
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_PARTICLE_NUM = 220;  // cell memory depth, word 0 = count

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    CNT_REQ,
    CNT_WAIT1,
    CNT_WAIT2,
    STREAM,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/pos_cell_reader_fifo.sv
// 4-entry shift FIFO of {index, data} for the reader output.
// Entry 0 is the head and is read straight out of its registers, so the
// consumer sees registered out_* signals. A read shifts every entry down;
// a write lands in the first free slot after any shift.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en/index/data  push one returning memory word
//   rd_en             consumer accepts the head (ignored when empty)
//   head_index/data   current head contents
//   full, empty,count occupancy flags (count includes the head)
module pos_cell_reader_fifo
  import md_pos_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_index,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] head_index,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] ent_data, nxt_data;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] ent_idx, nxt_idx;
  logic [FIFO_DEPTH-1:0]                 ent_vld, nxt_vld;
  logic [FIFO_CNT_W-1:0]                 cnt_q, nxt_cnt;
  logic [FIFO_PTR_W-1:0]                 wr_pos;
  logic                                  do_rd, do_wr;

  assign do_rd = rd_en & ent_vld[0];
  // A write into a full FIFO is only taken when the head leaves the same cycle.
  assign do_wr = wr_en & (~ent_vld[FIFO_DEPTH-1] | do_rd);
  assign wr_pos = do_rd ? FIFO_PTR_W'(cnt_q - FIFO_CNT_W'(1)) : FIFO_PTR_W'(cnt_q);

  always_comb begin
    nxt_data = ent_data;
    nxt_idx  = ent_idx;
    nxt_vld  = ent_vld;
    nxt_cnt  = cnt_q;
    if (do_rd) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        nxt_data[i] = ent_data[i+1];
        nxt_idx[i]  = ent_idx[i+1];
        nxt_vld[i]  = ent_vld[i+1];
      end
      nxt_vld[FIFO_DEPTH-1] = 1'b0;
      nxt_cnt = nxt_cnt - FIFO_CNT_W'(1);
    end
    if (do_wr) begin
      nxt_data[wr_pos] = wr_data;
      nxt_idx[wr_pos]  = wr_index;
      nxt_vld[wr_pos]  = 1'b1;
      nxt_cnt = nxt_cnt + FIFO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_data <= '0;
      ent_idx  <= '0;
      ent_vld  <= '0;
      cnt_q    <= '0;
    end else begin
      ent_data <= nxt_data;
      ent_idx  <= nxt_idx;
      ent_vld  <= nxt_vld;
      cnt_q    <= nxt_cnt;
    end
  end

  assign head_index = ent_idx[0];
  assign head_data  = ent_data[0];
  assign empty      = ~ent_vld[0];
  assign full       = ent_vld[FIFO_DEPTH-1];
  assign count      = cnt_q;

endmodule

// File: rtl/pos_cell_reader.sv
// Streams the particle positions of one cell out of a 2-cycle-latency
// cell memory. Word 0 holds the particle count, words 1..count hold
// {posz, posy, posx}. Each start reads the count, then issues ascending
// reads while the output FIFO has room for everything in flight, and
// presents the words on a valid/ready port tagged with their address.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, busy, done   request / activity / end-of-stream pulse
//   mem_*               cell memory port (read only; wren/data tied 0)
//   out_*               particle stream, transfer = out_valid & out_ready
//   particle_count      latched (clamped) count of the last cell
//   count_err           sticky: a count larger than PARTICLE_NUM-1 was seen
module pos_cell_reader
  import md_pos_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int PARTICLE_NUM = DEF_PARTICLE_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err
);

  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  rd_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0]      raw_cnt, rd_addr, addr_q;
  logic                       over, cnt_zero, rd_issue, room, xfer;
  logic [1:0]                 vld_pipe;   // in-flight reads, [1] returns this cycle
  logic [1:0][ADDR_WIDTH-1:0] idx_pipe;
  logic                       fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0]      fifo_cnt;

  assign raw_cnt  = mem_q[ADDR_WIDTH-1:0];
  assign over     = raw_cnt > MAX_CNT;
  assign cnt_zero = raw_cnt == '0;
  assign xfer     = out_valid & out_ready;

  // Credit check: every read already in flight owns a FIFO slot, so a new
  // read goes out only if FIFO + in-flight + this one fit in the FIFO.
  assign room = ~fifo_full &
                (({1'b0, fifo_cnt} + 4'(vld_pipe[0]) + 4'(vld_pipe[1])) < 4'(FIFO_DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = CNT_REQ;
      CNT_REQ:   state_nxt = CNT_WAIT1;
      CNT_WAIT1: state_nxt = CNT_WAIT2;
      CNT_WAIT2: state_nxt = cnt_zero ? IDLE : STREAM;
      STREAM:    if (room && rd_addr == particle_count) state_nxt = DRAIN;
      DRAIN:     if (xfer && out_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = state != IDLE;
    rd_issue = 1'b0;
    case (state)
      CNT_REQ: rd_issue = 1'b1;
      STREAM:  rd_issue = room;
      default: rd_issue = 1'b0;
    endcase
  end

  // Address is held between reads so the memory bus only toggles on issue.
  assign mem_rden    = rd_issue;
  assign mem_address = (state == CNT_REQ) ? '0 : (rd_issue ? rd_addr : addr_q);
  assign mem_wren    = 1'b0;
  assign mem_data    = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      done           <= 1'b0;
      addr_q         <= '0;
      rd_addr        <= '0;
      vld_pipe       <= '0;
      idx_pipe       <= '0;
      particle_count <= '0;
      count_err      <= 1'b0;
    end else begin
      done     <= (state == CNT_WAIT2 && cnt_zero) || (state == DRAIN && xfer && out_last);
      vld_pipe <= {vld_pipe[0], rd_issue && state == STREAM};
      idx_pipe <= {idx_pipe[0], rd_addr};
      if (rd_issue) addr_q <= mem_address;
      if (state == CNT_WAIT2) begin
        particle_count <= over ? MAX_CNT : raw_cnt;
        count_err      <= count_err | over;
        rd_addr        <= ADDR_WIDTH'(1);
      end else if (state == STREAM && rd_issue) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
      end
    end
  end

  pos_cell_reader_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (vld_pipe[1]),
    .wr_index   (idx_pipe[1]),
    .wr_data    (mem_q),
    .rd_en      (out_ready),
    .head_index (out_index),
    .head_data  (out_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_cnt)
  );

  assign out_valid = ~fifo_empty;
  assign out_last  = (out_index == particle_count) & out_valid;

endmodule

// File: tb/tb_pos_cell_reader.sv
module tb_pos_cell_reader;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic          busy, done, mem_rden, mem_wren, out_valid, out_last, count_err;
  logic [AW-1:0] mem_address, out_index, particle_count;
  logic [DW-1:0] mem_data, mem_q, out_data;

  pos_cell_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_data(mem_data), .mem_q(mem_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .particle_count(particle_count), .count_err(count_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cell memory: 2-cycle read latency.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] q1;
  always @(posedge clk) begin
    q1    <= mem[mem_address];
    mem_q <= q1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Consumer: mode 1 = always ready, mode 2 = random with 3-cycle stalls.
  int rdy_mode = 1;
  int stall = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = 1'b1;
    else if (stall > 0) begin out_ready = 1'b0; stall--; end
    else if ($urandom_range(0, 3) == 0) begin out_ready = 1'b0; stall = 2; end
    else out_ready = 1'($urandom_range(0, 1));
  end

  // Reference model: an accepted start expects words 1..min(count,PN-1) in order.
  typedef struct { logic [AW-1:0] idx; logic [DW-1:0] data; } item_t;
  item_t exp_q[$];
  int issued, xfers, exp_addr, s_cyc, first_vld, first_x, last_x, vld_cnt;
  bit prev_stall;
  logic [DW-1:0] p_data;
  logic [AW-1:0] p_idx;
  logic p_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      issued = 0; xfers = 0; exp_addr = 1; prev_stall = 0; vld_cnt = 0;
    end else begin
      if (start && !busy) begin
        int n;
        n = (int'(mem[0][AW-1:0]) > PN - 1) ? PN - 1 : int'(mem[0][AW-1:0]);
        exp_q.delete();
        for (int i = 1; i <= n; i++) exp_q.push_back('{idx: AW'(i), data: mem[i]});
        issued = 0; xfers = 0; exp_addr = 1; s_cyc = cyc;
        first_vld = -1; first_x = -1; last_x = -1; vld_cnt = 0; prev_stall = 0;
      end
      if (mem_rden && mem_address != 0) begin
        chk("read_addr", mem_address, exp_addr);
        exp_addr++; issued++;
        chk("outstanding_le4", (issued - xfers) <= 4, 1);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, p_data);
        chk("stall_index", out_index, p_idx);
        chk("stall_last", out_last, p_last);
      end
      if (out_valid) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_transfer: got index %0d expected no transfer", out_index);
        end else begin
          chk("xfer_index", out_index, exp_q[0].idx);
          chk("xfer_data", out_data, exp_q[0].data);
          chk("xfer_last", out_last, exp_q.size() == 1);
          void'(exp_q.pop_front());
        end
        xfers++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      prev_stall = out_valid && !out_ready;
      p_data = out_data; p_idx = out_index; p_last = out_last;
    end
  end

  bit model_err = 0;

  task automatic run_cell(input int raw, input int mode, input bit extra,
                          input int exp_pc, input int exp_n);
    int s, dcyc;
    bit got;
    rdy_mode = mode;
    mem[0] = DW'(raw);
    for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    model_err = model_err | (raw > PN - 1);
    @(posedge clk); #1;
    start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("count_rden", mem_rden, 1);
    chk("count_addr", mem_address, 0);
    if (extra) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    got = 0;
    for (int k = 0; k < 4000 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    dcyc = cyc;
    chk("busy_at_done", busy, 0);
    chk("particle_count", particle_count, exp_pc);
    chk("count_err", count_err, model_err);
    chk("transfers", xfers, exp_n);
    chk("queue_drained", exp_q.size(), 0);
    if (exp_n == 0) begin
      chk("zero_no_valid", vld_cnt, 0);
      chk("zero_done_cycle", dcyc, s + 4);
    end else begin
      chk("done_after_last", dcyc, last_x + 1);
      if (mode == 1) begin
        chk("first_valid_cycle", first_vld, s + 7);
        chk("back_to_back", last_x - first_x, exp_n - 1);
      end
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    if (extra) begin
      repeat (3) @(negedge clk);
      chk("extra_start_ignored", busy, 0);
    end
  endtask

  typedef struct { int raw; int mode; bit extra; int exp_pc; int exp_n; } vec_t;

  initial begin
    vec_t vecs[9];
    int s, r;
    vecs[0] = '{5,   1, 1'b0, 5,   5};
    vecs[1] = '{0,   1, 1'b0, 0,   0};
    vecs[2] = '{1,   1, 1'b0, 1,   1};
    vecs[3] = '{10,  2, 1'b0, 10,  10};
    vecs[4] = '{5,   1, 1'b1, 5,   5};
    vecs[5] = '{219, 1, 1'b0, 219, 219};
    vecs[6] = '{220, 2, 1'b0, 219, 219};
    vecs[7] = '{250, 1, 1'b0, 219, 219};
    vecs[8] = '{255, 2, 1'b0, 219, 219};

    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_mem_rden", mem_rden, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_particle_count", particle_count, 0);
    chk("rst_count_err", count_err, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < 9; v++)
      run_cell(vecs[v].raw, vecs[v].mode, vecs[v].extra, vecs[v].exp_pc, vecs[v].exp_n);

    // Reset with two data reads in flight.
    rdy_mode = 1;
    mem[0] = DW'(10);
    for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_start_cycle", cyc, s + 6);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rden", mem_rden, 0);
    chk("midrst_count", particle_count, 0);
    chk("midrst_count_err", count_err, 0);
    model_err = 0;
    repeat (8) @(negedge clk);
    chk("midrst_no_stale", vld_cnt, 0);
    run_cell(7, 2, 1'b0, 7, 7);

    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(0, 255);
      run_cell(r, 2, 1'b0, (r > PN - 1) ? PN - 1 : r, (r > PN - 1) ? PN - 1 : r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pos_cell_reader.md
POS_CELL_READER -- requirements
Module: pos_cell_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 96, position word width {posz, posy, posx}, 32 bits each.
REQ-002 Parameter ADDR_WIDTH, default 8, cell memory address width.
REQ-003 Parameter PARTICLE_NUM, default 220, cell memory depth in words, address 0 included.
REQ-004 Port clock  in  1  sole clock; every register updates on its rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  single-cycle request to stream one cell.
REQ-007 Port busy  out  1  high from the cycle after start is accepted until done.
REQ-008 Port done  out  1  one-cycle pulse at the end of the stream.
REQ-009 Port mem_address  out  ADDR_WIDTH  cell memory address.
REQ-010 Port mem_rden  out  1  cell memory read enable.
REQ-011 Port mem_wren  out  1  tied 0.
REQ-012 Port mem_data  out  DATA_WIDTH  tied 0.
REQ-013 Port mem_q  in  DATA_WIDTH  cell memory read data, valid 2 cycles after the address and rden.
REQ-014 Port out_valid  out  1  out_data holds a valid particle.
REQ-015 Port out_ready  in  1  consumer accepts; transfer = out_valid & out_ready.
REQ-016 Port out_data  out  DATA_WIDTH  particle position.
REQ-017 Port out_index  out  ADDR_WIDTH  memory address of the particle (1..count).
REQ-018 Port out_last  out  1  marks the final particle of the cell.
REQ-019 Port particle_count  out  ADDR_WIDTH  latched count, clamped.
REQ-020 Port count_err  out  1  sticky; set when the raw count exceeds PARTICLE_NUM-1.

Function
REQ-021 FSM states: IDLE, CNT_REQ, CNT_WAIT1, CNT_WAIT2, STREAM, DRAIN.
REQ-022 IDLE: start=1 -> CNT_REQ; start is ignored in every other state.
REQ-023 CNT_REQ: drive mem_address=0 and mem_rden=1 for one cycle -> CNT_WAIT1 -> CNT_WAIT2.
REQ-024 CNT_WAIT2: latch count = mem_q[ADDR_WIDTH-1:0].
REQ-025 Count clamp: if the count exceeds PARTICLE_NUM-1, latch PARTICLE_NUM-1 and set count_err.
REQ-026 Zero count: from CNT_WAIT2 go to IDLE, pulse done in the same cycle, assert no out_valid.
REQ-027 STREAM: issue reads at ascending addresses 1..count, at most one per cycle.
REQ-028 Issue rule: issue a read only when FIFO occupancy + in-flight reads + 1 <= 4.
REQ-029 Issue tracking: a 2-stage valid/index shift register tracks in-flight reads; returning mem_q is written into the FIFO with its index.
REQ-030 STREAM -> DRAIN once address count has been issued.
REQ-031 DRAIN -> IDLE on the transfer of out_last; done pulses in the cycle after that transfer.
REQ-032 Output: out_valid, out_data, out_index and out_last come from registered FIFO head storage.
REQ-033 out_last = (out_index == particle_count) & out_valid.
REQ-034 Output stability: while out_valid=1 and out_ready=0, all out_* signals hold stable.
REQ-035 Throughput: with out_ready held 1, one transfer per cycle after the first.
REQ-036 Latency: for start sampled in cycle s, address 0 is driven in s+1 and the first out_valid rises in s+7.
REQ-037 Simultaneous FIFO write and read at full occupancy is legal; occupancy is unchanged.
REQ-038 mem_rden=0 whenever no read is issued; mem_address then holds its last value.

Reset
REQ-039 rst=1 forces: state IDLE, FIFO empty, in-flight tracking cleared, count_err=0, particle_count=0.
REQ-040 rst=1 also drives busy, done, out_valid, out_last and mem_rden to 0, and out_data, out_index and mem_address to 0.
REQ-041 Reset mid-stream cancels all in-flight reads; data returning after reset is discarded.

Structure
REQ-042 Package md_pos_pkg holds the FSM state enum, the FIFO depth constant (4) and the default widths.
REQ-043 Sub-module pos_cell_reader_fifo: 4-entry synchronous FIFO of {index, data} with registered outputs and full/empty/count flags.

Verification
REQ-044 Address 0 = 5, out_ready=1: 5 transfers with indices 1..5 on consecutive cycles, out_last on index 5, done one cycle later, first out_valid at s+7.
REQ-045 Address 0 = 0: done pulses 3 cycles after CNT_REQ, out_valid never asserts, busy drops with done.
REQ-046 Address 0 = 250 with PARTICLE_NUM=220: particle_count=219, count_err=1, exactly 219 transfers.
REQ-047 Count 10, out_ready toggling randomly with 3-cycle stalls: data is in order and stable during stalls, never more than 4 FIFO entries plus in-flight reads outstanding, no loss or duplication.
REQ-048 rst asserted while 2 reads are in flight: out_valid=0 next cycle, no stale data appears, a new start streams correctly.
REQ-049 Start pulsed while busy: ignored, current stream completes unchanged.
